// File: rtl/sysid_check_master_if.sv
// rtl/sysid_check_master_if.sv - Avalon-MM read bus between the sysid check master and the sysid slave
interface sysid_check_master_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - reads sysid words 0/1 and checks them; SYSID_CHECK_TIMEOUT_EN adds a stall timeout
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1522708869,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    sysid_check_master_if.master       avm,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [31:0]                id_q,
    output logic [31:0]                ts_q
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CMP,
        ABORT
    } state_t;

    state_t state, state_next;

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] stall_cnt;
    logic        stall_hit;
    logic        timeout_q;

    // Abort on the stall cycle that brings the count up to TIMEOUT_CYCLES.
    assign stall_hit = avm.avm_waitrequest && (stall_cnt == STALL_LAST);
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        avm.avm_read    = 1'b0;
        avm.avm_address = 1'b0;
        done            = 1'b0;
        busy            = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RD_ID;
                end
            end
            RD_ID: begin
                avm.avm_read = 1'b1;
                if (!avm.avm_waitrequest) begin
                    state_next = RD_TS;
                end
`ifdef SYSID_CHECK_TIMEOUT_EN
                else if (stall_hit) begin
                    state_next = ABORT;
                end
`endif
            end
            RD_TS: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = 1'b1;
                if (!avm.avm_waitrequest) begin
                    state_next = CMP;
                end
`ifdef SYSID_CHECK_TIMEOUT_EN
                else if (stall_hit) begin
                    state_next = ABORT;
                end
`endif
            end
            CMP: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ABORT: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass <= 1'b0;
            id_q <= 32'h0;
            ts_q <= 32'h0;
        end else begin
            case (state)
                IDLE:    if (start) pass <= 1'b0;
                RD_ID:   if (!avm.avm_waitrequest) id_q <= avm.avm_readdata;
                RD_TS:   if (!avm.avm_waitrequest) ts_q <= avm.avm_readdata;
                CMP:     pass <= (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
                ABORT:   pass <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SYSID_CHECK_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'h0;
            timeout_q <= 1'b0;
        end else begin
            // Any state change restarts the count so each word gets its own budget.
            if (state_next != state) begin
                stall_cnt <= 16'h0;
            end else if (avm.avm_read && avm.avm_waitrequest) begin
                stall_cnt <= stall_cnt + 16'h1;
            end
            if (state == IDLE && start) begin
                timeout_q <= 1'b0;
            end else if (state == ABORT) begin
                timeout_q <= 1'b1;
            end
        end
    end
`endif

endmodule
